// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK0, ARB_LOCK1} arb_state_e;
  typedef logic arb_mst_t;
  localparam int ARB_NUM_MST = 2;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter with lock/timeout in front of single-ported data_mem
// Ports: clk/reset; per master mN_req/we/addr/wdata/lock in, mN_gnt/rvalid/rdata out;
// mem_addr/wr_en/wr_data/rd_en out and mem_ld_data in (asynchronous-read data_mem); lock_err pulse out.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 32,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_lock,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_ld_data,
  output logic                  lock_err
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  arb_state_e state, state_nx;
  arb_mst_t last_gnt, last_gnt_nx, owner;
  logic [CW-1:0] lock_cnt, lock_cnt_nx;
  logic locked, owner_req, timeout, acc0, acc1, acc, win_lock;
  logic rv0_q, rv1_q;
  logic [DATA_WIDTH-1:0] rd0_q, rd1_q;
  always_comb begin
    locked = state != ARB_IDLE;
    owner = arb_mst_t'(state == ARB_LOCK1);
    owner_req = owner ? m1_req : m0_req;
    m0_gnt = !reset && m0_req && (locked ? !owner : (!m1_req || last_gnt));
    m1_gnt = !reset && m1_req && (locked ? owner : (!m0_req || !last_gnt));
    acc0 = m0_gnt;
    acc1 = m1_gnt;
    acc = acc0 || acc1;
    win_lock = acc1 ? m1_lock : m0_lock;
    mem_addr = acc1 ? m1_addr : acc0 ? m0_addr : '0;
    mem_wr_data = acc1 ? m1_wdata : acc0 ? m0_wdata : '0;
    mem_wr_en = acc1 ? m1_we : acc0 && m0_we;
    mem_rd_en = acc1 ? !m1_we : acc0 && !m0_we;
    // Fires in the idle locked cycle that would bring the count to LOCK_TIMEOUT; an owner request that cycle pre-empts it.
    timeout = !reset && locked && !owner_req && lock_cnt == CW'(LOCK_TIMEOUT - 1);
    lock_err = timeout;
    state_nx = acc ? (win_lock ? (acc1 ? ARB_LOCK1 : ARB_LOCK0) : ARB_IDLE) : timeout ? ARB_IDLE : state;
    last_gnt_nx = acc ? arb_mst_t'(acc1) : timeout ? owner : last_gnt;
    lock_cnt_nx = (acc || timeout || !locked) ? '0 : lock_cnt + CW'(1);
    // Read responses are suppressed while reset is held, even if registered the edge before.
    m0_rvalid = rv0_q && !reset;
    m1_rvalid = rv1_q && !reset;
    m0_rdata = reset ? '0 : rd0_q;
    m1_rdata = reset ? '0 : rd1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state <= state_nx;
      last_gnt <= last_gnt_nx;
      lock_cnt <= lock_cnt_nx;
      rv0_q <= acc0 && !m0_we;
      rv1_q <= acc1 && !m1_we;
      if (acc0 && !m0_we) rd0_q <= mem_ld_data;
      if (acc1 && !m1_we) rd1_q <= mem_ld_data;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with directed scenarios and random traffic
module tb_dmem_arbiter;
  localparam int LT = 4;
  typedef struct packed {
    logic req;
    logic we;
    logic [4:0] addr;
    logic [31:0] wd;
    logic lock;
  } mreq_t;
  typedef struct packed {
    logic g0;
    logic g1;
    logic [4:0] addr;
    logic wen;
    logic [31:0] wd;
    logic ren;
    logic lerr;
    logic rv0;
    logic rv1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [4:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wr_en, mem_rd_en, lock_err;
  logic [31:0] m0_rdata, m1_rdata, mem_wr_data, mem_ld_data;
  logic [4:0] mem_addr;
  logic [31:0] dmem [32];

  dmem_arbiter #(.DATA_WIDTH(32), .MEM_SIZE(32), .ADDR_WIDTH(5), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en),
    .mem_ld_data(mem_ld_data), .lock_err(lock_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_wr_en) dmem[mem_addr] <= mem_wr_data;
  assign mem_ld_data = dmem[mem_addr];

  exp_t exp_q [$];
  int checks = 0, errors = 0;
  int owner = -1, last = 1, idle = 0;
  logic rvq [2] = '{1'b0, 1'b0};
  logic [31:0] rdq [2] = '{32'h0, 32'h0};
  logic [31:0] ref_mem [32];
  mreq_t pq [2];
  logic [1:0] pg = '0;

  function automatic mreq_t nop();
    return '0;
  endfunction
  function automatic mreq_t rd(input logic [4:0] a, input logic l);
    return '{1'b1, 1'b0, a, 32'h0, l};
  endfunction
  function automatic mreq_t wr(input logic [4:0] a, input logic [31:0] d, input logic l);
    return '{1'b1, 1'b1, a, d, l};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, derive the expected observation from the reference model, advance the model.
  task automatic cyc(input logic rs, input mreq_t s0, input mreq_t s1);
    mreq_t q [2];
    logic [1:0] g;
    int a;
    exp_t e;
    q[0] = s0;
    q[1] = s1;
    @(negedge clk);
    reset = rs;
    {m0_req, m0_we, m0_addr, m0_wdata, m0_lock} = s0;
    {m1_req, m1_we, m1_addr, m1_wdata, m1_lock} = s1;
    #1;
    g = '0;
    e = '0;
    if (!rs) begin
      if (owner >= 0) g[owner] = q[owner].req;
      else if (s0.req && s1.req) g[1 - last] = 1'b1;
      else g = {s1.req, s0.req};
    end
    a = g[0] ? 0 : g[1] ? 1 : -1;
    e.g0 = g[0];
    e.g1 = g[1];
    if (a >= 0) begin
      e.addr = q[a].addr;
      e.wen = q[a].we;
      e.wd = q[a].wd;
      e.ren = !q[a].we;
    end
    e.lerr = !rs && owner >= 0 && !q[owner].req && idle + 1 == LT;
    e.rv0 = !rs && rvq[0];
    e.rv1 = !rs && rvq[1];
    e.rd0 = rs ? 32'h0 : rdq[0];
    e.rd1 = rs ? 32'h0 : rdq[1];
    exp_q.push_back(e);
    if (rs) begin
      owner = -1;
      last = 1;
      idle = 0;
      rvq = '{1'b0, 1'b0};
      rdq = '{32'h0, 32'h0};
    end else begin
      rvq = '{1'b0, 1'b0};
      if (a >= 0) begin
        if (q[a].we) ref_mem[q[a].addr] = q[a].wd;
        else begin
          rvq[a] = 1'b1;
          rdq[a] = ref_mem[q[a].addr];
        end
        owner = q[a].lock ? a : -1;
        last = a;
        idle = 0;
      end else if (owner >= 0) begin
        if (e.lerr) begin
          last = owner;
          owner = -1;
          idle = 0;
        end else idle++;
      end
    end
    pq = q;
    pg = g;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(e.wen));
        chk("mem_wr_data", mem_wr_data, e.wd);
        chk("mem_rd_en", 32'(mem_rd_en), 32'(e.ren));
        chk("lock_err", 32'(lock_err), 32'(e.lerr));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(e.rv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(e.rv1));
        chk("m0_rdata", m0_rdata, e.rd0);
        chk("m1_rdata", m1_rdata, e.rd1);
      end
    end
  end

  initial begin
    mreq_t n [2];
    logic rs;
    for (int i = 0; i < 32; i++) begin
      dmem[i] = 32'h1000_0000 + 32'(i * 7);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
    end
    cyc(1, nop(), nop());
    cyc(1, nop(), nop());
    cyc(0, wr(5, 32'hDEAD_BEEF, 0), nop());
    cyc(0, rd(5, 0), nop());
    cyc(0, nop(), nop());
    cyc(1, nop(), nop());
    cyc(0, rd(1, 0), rd(2, 0));
    cyc(0, rd(1, 0), rd(2, 0));
    cyc(0, rd(1, 0), rd(2, 0));
    cyc(0, rd(1, 0), rd(2, 0));
    cyc(0, nop(), nop());
    cyc(0, rd(11, 0), nop());
    cyc(0, rd(7, 0), rd(3, 1));
    cyc(0, rd(7, 0), nop());
    cyc(0, rd(7, 0), wr(3, 32'h1234_5678, 0));
    cyc(0, rd(7, 0), nop());
    cyc(0, rd(3, 0), nop());
    cyc(0, wr(10, 32'hA5A5_A5A5, 1), nop());
    for (int i = 0; i < 6; i++) cyc(0, nop(), rd(9, 0));
    cyc(0, rd(4, 0), nop());
    cyc(1, nop(), nop());
    cyc(0, rd(6, 0), rd(8, 0));
    cyc(0, nop(), rd(8, 0));
    cyc(0, nop(), nop());
    for (int k = 0; k < 600; k++) begin
      rs = $urandom_range(0, 99) == 0;
      for (int i = 0; i < 2; i++) begin
        if (pq[i].req && !pg[i]) n[i] = pq[i];
        else if ($urandom_range(0, 1) == 1) begin
          n[i] = $urandom_range(0, 1) == 1
            ? wr(5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3) == 0)
            : rd(5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
        end else n[i] = nop();
      end
      cyc(rs, n[0], n[1]);
    end
    cyc(0, nop(), nop());
    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
